// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation best-MV selector.
// Widths, MV offsets, sub-block count, FSM state encoding, MV helper.
package me_pkg;

    localparam int SAD_W  = 16;
    localparam int COL_W  = 5;
    localparam int ROW_W  = 7;
    localparam int MV_W   = 8;
    localparam int NUM_CB = 4;
    localparam int CB_W   = 2;

    localparam logic [MV_W-1:0] COL_OFS = MV_W'(16);
    localparam logic [MV_W-1:0] ROW_OFS = MV_W'(32);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Operand is already zero-extended to MV_W; result wraps as two's complement.
    function automatic logic signed [MV_W-1:0] mv_ofs(
        input logic [MV_W-1:0] v,
        input logic [MV_W-1:0] ofs
    );
        return $signed(v - ofs);
    endfunction

endpackage

// File: rtl/me_min_cell.sv
// One sub-block's running minimum: best SAD, its MV and a seen-flag.
// Ports: clk, rst, clr, en, sad, mv_x, mv_y -> best_sad, best_mv_x, best_mv_y, hit.
module me_min_cell
    import me_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic [SAD_W-1:0]       sad,
    input  logic signed [MV_W-1:0] mv_x,
    input  logic signed [MV_W-1:0] mv_y,
    output logic [SAD_W-1:0]       best_sad,
    output logic signed [MV_W-1:0] best_mv_x,
    output logic signed [MV_W-1:0] best_mv_y,
    output logic                   hit
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_sad  <= '1;
            best_mv_x <= '0;
            best_mv_y <= '0;
            hit       <= 1'b0;
        end else if (clr) begin
            best_sad  <= '1;
            best_mv_x <= '0;
            best_mv_y <= '0;
            hit       <= 1'b0;
        end else if (en) begin
            // Any candidate counts as seen; strict less-than keeps the earliest tie.
            hit <= 1'b1;
            if (sad < best_sad) begin
                best_sad  <= sad;
                best_mv_x <= mv_x;
                best_mv_y <= mv_y;
            end
        end
    end

endmodule

// File: rtl/me_best_mv_select.sv
// Tracks per-sub-block minimum SAD + MV during a search, then drains 4 results.
// Ports: clk, rst, clear, sad_valid/sad_in/cb_idx/col_in/row_in, search_done, out_* handshake, busy, overrun.
module me_best_mv_select
    import me_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   sad_valid,
    input  logic [SAD_W-1:0]       sad_in,
    input  logic [CB_W-1:0]        cb_idx,
    input  logic [COL_W-1:0]       col_in,
    input  logic [ROW_W-1:0]       row_in,
    input  logic                   search_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CB_W-1:0]        out_cb,
    output logic [SAD_W-1:0]       out_sad,
    output logic signed [MV_W-1:0] out_mv_x,
    output logic signed [MV_W-1:0] out_mv_y,
    output logic                   out_hit,
    output logic                   busy,
    output logic                   overrun
);

    state_t          state;
    logic [CB_W-1:0] drain_idx;
    logic            drain_valid;

    logic [NUM_CB-1:0]       cell_en;
    logic [SAD_W-1:0]        cell_sad  [NUM_CB];
    logic signed [MV_W-1:0]  cell_mv_x [NUM_CB];
    logic signed [MV_W-1:0]  cell_mv_y [NUM_CB];
    logic [NUM_CB-1:0]       cell_hit;

    logic signed [MV_W-1:0]  cand_mv_x;
    logic signed [MV_W-1:0]  cand_mv_y;
    logic                    accept;

    assign cand_mv_x = mv_ofs(MV_W'(col_in), COL_OFS);
    assign cand_mv_y = mv_ofs(MV_W'(row_in), ROW_OFS);
    assign accept    = drain_valid & out_ready;

    always_comb begin
        cell_en = '0;
        if (state == ST_TRACK && sad_valid)
            cell_en[cb_idx] = 1'b1;
    end

    for (genvar g = 0; g < NUM_CB; g++) begin : g_cell
        me_min_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .clr       (clear),
            .en        (cell_en[g]),
            .sad       (sad_in),
            .mv_x      (cand_mv_x),
            .mv_y      (cand_mv_y),
            .best_sad  (cell_sad[g]),
            .best_mv_x (cell_mv_x[g]),
            .best_mv_y (cell_mv_y[g]),
            .hit       (cell_hit[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            drain_idx   <= '0;
            drain_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else if (clear) begin
            state       <= ST_TRACK;
            drain_idx   <= '0;
            drain_valid <= 1'b0;
            busy        <= 1'b1;
            overrun     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (sad_valid)
                        overrun <= 1'b1;
                end
                ST_TRACK: begin
                    // A same-cycle sample lands in the cell on this same edge.
                    if (search_done) begin
                        state       <= ST_DRAIN;
                        drain_idx   <= '0;
                        drain_valid <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (sad_valid)
                        overrun <= 1'b1;
                    if (accept) begin
                        if (drain_idx == CB_W'(NUM_CB - 1)) begin
                            state       <= ST_IDLE;
                            drain_valid <= 1'b0;
                            busy        <= 1'b0;
                        end else begin
                            drain_idx <= drain_idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Cells are frozen outside TRACK, so selecting by a registered index
    // keeps the presented result stable under backpressure.
    always_comb begin
        out_valid = drain_valid;
        out_cb    = '0;
        out_sad   = '0;
        out_mv_x  = '0;
        out_mv_y  = '0;
        out_hit   = 1'b0;
        if (drain_valid) begin
            out_cb   = drain_idx;
            out_sad  = cell_sad[drain_idx];
            out_mv_x = cell_mv_x[drain_idx];
            out_mv_y = cell_mv_y[drain_idx];
            out_hit  = cell_hit[drain_idx];
        end
    end

endmodule

// File: tb/tb_me_best_mv_select.sv
// Scoreboard bench for me_best_mv_select: directed vectors, queued expectations.
// A negedge monitor pops and compares on every accepted result.
module tb_me_best_mv_select;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              sad_valid;
    logic [15:0]       sad_in;
    logic [1:0]        cb_idx;
    logic [4:0]        col_in;
    logic [6:0]        row_in;
    logic              search_done;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_cb;
    logic [15:0]       out_sad;
    logic signed [7:0] out_mv_x;
    logic signed [7:0] out_mv_y;
    logic              out_hit;
    logic              busy;
    logic              overrun;

    typedef struct {
        logic [1:0]  cb;
        logic [15:0] sad;
        logic [7:0]  mx;
        logic [7:0]  my;
        logic        hit;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    me_best_mv_select dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .sad_valid   (sad_valid),
        .sad_in      (sad_in),
        .cb_idx      (cb_idx),
        .col_in      (col_in),
        .row_in      (row_in),
        .search_done (search_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_cb      (out_cb),
        .out_sad     (out_sad),
        .out_mv_x    (out_mv_x),
        .out_mv_y    (out_mv_y),
        .out_hit     (out_hit),
        .busy        (busy),
        .overrun     (overrun)
    );

    // Monitor: a handshake happens on the next posedge when valid & ready now.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL drain_unexpected: got cb=%0d sad=%h, need no result", out_cb, out_sad);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_cb !== e.cb || out_sad !== e.sad || out_mv_x !== e.mx ||
                    out_mv_y !== e.my || out_hit !== e.hit) begin
                    n_err++;
                    $display("FAIL drain_cb%0d: got cb=%0d sad=%h mv=(%0d,%0d) hit=%0b, need cb=%0d sad=%h mv=(%0d,%0d) hit=%0b",
                             e.cb, out_cb, out_sad, out_mv_x, out_mv_y, out_hit,
                             e.cb, e.sad, $signed(e.mx), $signed(e.my), e.hit);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, need %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int cb, input int sad, input int mx, input int my, input int hit);
        exp_t e;
        e.cb  = 2'(cb);
        e.sad = 16'(sad);
        e.mx  = 8'(mx);
        e.my  = 8'(my);
        e.hit = 1'(hit);
        q.push_back(e);
    endtask

    task automatic push_empty(input int cb);
        push(cb, 'hFFFF, 0, 0, 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic send(input int cb, input int sad, input int col, input int row);
        sad_valid = 1'b1;
        cb_idx    = 2'(cb);
        sad_in    = 16'(sad);
        col_in    = 5'(col);
        row_in    = 7'(row);
        @(posedge clk); #1;
        sad_valid = 1'b0;
    endtask

    task automatic done_pulse();
        search_done = 1'b1;
        @(posedge clk); #1;
        search_done = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int i;
        for (i = 0; i < lim; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        chk(nm, int'(busy), 0);
    endtask

    logic [15:0]       h_sad;
    logic signed [7:0] h_mx;
    logic signed [7:0] h_my;

    initial begin
        rst = 1'b1; clear = 1'b0; sad_valid = 1'b0; sad_in = '0;
        cb_idx = '0; col_in = '0; row_in = '0; search_done = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sad", int'(out_sad), 0);
        chk("rst_out_mv_x", int'(out_mv_x), 0);
        chk("rst_out_hit", int'(out_hit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic: earliest of the tied 300s wins.
        out_ready = 1'b1;
        pulse_clear();
        chk("t1_busy", int'(busy), 1);
        send(0, 500, 3, 10);
        send(0, 300, 5, 40);
        send(0, 300, 9, 2);
        push(0, 300, -11, 8, 1);
        push_empty(1); push_empty(2); push_empty(3);
        done_pulse();
        chk("t1_valid_first", int'(out_valid), 1);
        wait_idle("t1_idle", 20);

        // Backpressure on CB1, all-ones SAD, extreme MVs.
        pulse_clear();
        send(1, 100, 16, 32);
        send(2, 'hFFFF, 7, 7);
        send(3, 0, 31, 127);
        send(1, 200, 0, 0);
        push_empty(0);
        push(1, 100, 0, 0, 1);
        push(2, 'hFFFF, 0, 0, 1);
        push(3, 0, 15, 95, 1);
        out_ready = 1'b1;
        done_pulse();
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t2_hold_cb", int'(out_cb), 1);
        h_sad = out_sad; h_mx = out_mv_x; h_my = out_mv_y;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t2_hold_valid", int'(out_valid), 1);
            chk("t2_hold_cb", int'(out_cb), 1);
            chk("t2_hold_sad", int'(out_sad), int'(h_sad));
            chk("t2_hold_mv", int'({out_mv_x, out_mv_y}), int'({h_mx, h_my}));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t2_done_valid", int'(out_valid), 0);
        chk("t2_done_busy", int'(busy), 0);

        // Same-cycle sample with search_done.
        pulse_clear();
        send(2, 9, 1, 1);
        push_empty(0); push_empty(1);
        push(2, 7, -16, -32, 1);
        push_empty(3);
        sad_valid = 1'b1; cb_idx = 2'd2; sad_in = 16'd7; col_in = '0; row_in = '0;
        search_done = 1'b1;
        @(posedge clk); #1;
        sad_valid = 1'b0; search_done = 1'b0;
        wait_idle("t3_idle", 20);

        // Abort during DRAIN of CB1, with overrun set by a stray sample.
        pulse_clear();
        send(0, 50, 20, 40);
        push(0, 50, 4, 8, 1);
        out_ready = 1'b1;
        done_pulse();
        sad_valid = 1'b1; cb_idx = 2'd1; sad_in = 16'd1;
        @(posedge clk); #1;
        sad_valid = 1'b0;
        out_ready = 1'b0;
        chk("t4_overrun_set", int'(overrun), 1);
        chk("t4_cb1_shown", int'(out_cb), 1);
        pulse_clear();
        chk("t4_abort_valid", int'(out_valid), 0);
        chk("t4_abort_busy", int'(busy), 1);
        chk("t4_abort_overrun", int'(overrun), 0);
        send(3, 10, 16, 32);
        push_empty(0); push_empty(1); push_empty(2);
        push(3, 10, 0, 0, 1);
        out_ready = 1'b1;
        done_pulse();
        wait_idle("t4_idle", 20);

        // Overrun in IDLE.
        send(0, 1, 16, 32);
        chk("t5_overrun", int'(overrun), 1);
        chk("t5_busy", int'(busy), 0);
        chk("t5_valid", int'(out_valid), 0);
        pulse_clear();
        chk("t5_overrun_clr", int'(overrun), 0);
        push_empty(0); push_empty(1); push_empty(2); push_empty(3);
        done_pulse();
        wait_idle("t5_idle", 20);

        // Async reset mid-TRACK, then mid-DRAIN.
        pulse_clear();
        send(1, 5, 16, 32);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_track_busy", int'(busy), 0);
        chk("t6_track_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_pulse();
        chk("t6_done_ignored", int'(busy), 0);
        out_ready = 1'b0;
        pulse_clear();
        send(0, 3, 16, 32);
        done_pulse();
        chk("t6_drain_valid", int'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_drain_valid_rst", int'(out_valid), 0);
        chk("t6_drain_sad_rst", int'(out_sad), 0);
        chk("t6_drain_busy_rst", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
